notes_to_chord: RTL and testbench

NOTES_TO_CHORD -- requirements
Module: notes_to_chord

---
 rtl/notes_to_chord.sv | 103 ++++++++++
 tb/tb_notes_to_chord.sv | 131 +++++++++++++
 2 files changed

// File: rtl/notes_to_chord.sv
// notes_to_chord: collects pitch classes over a frame, then scores seven
// key-relative seventh-chord templates (one per cycle) and reports the best.
module notes_to_chord (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key,
    input  logic [3:0]  note_in,
    input  logic        note_valid,
    input  logic        frame_end,
    output logic        note_ready,
    output logic [3:0]  chord_out,
    output logic        chord_valid,
    input  logic        chord_ready,
    output logic [11:0] note_mask,
    output logic        bad_note
);
    typedef enum logic [1:0] {IDLE, COLLECT, MATCH, OUT} state_t;
    state_t state, nxt;
    logic [11:0] mask, pat, tmpl;
    logic        bad, accept, fire, better;
    logic [3:0]  key_l, off, root;
    logic [4:0]  rsum;
    logic [23:0] sh;
    logic [2:0]  idx, best, best_idx, score, fin_score, fin_idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, COLLECT: nxt = fire ? MATCH : accept ? COLLECT : state;
            MATCH:         nxt = idx == 3'd7 ? OUT : MATCH;
            OUT:           nxt = chord_ready ? IDLE : OUT;
        endcase
    end

    always_comb begin
        note_ready  = state == IDLE || state == COLLECT;
        chord_valid = state == OUT;
    end

    assign accept = note_valid && note_ready;
    assign fire   = frame_end && note_ready;

    // Current template: interval pattern rotated up to its root.
    always_comb begin
        off = idx == 3'd1 ? 4'd0 : idx == 3'd2 ? 4'd1 : idx == 3'd3 ? 4'd2 :
              idx == 3'd4 ? 4'd4 : idx == 3'd5 ? 4'd5 : 4'd6;
        pat = idx == 3'd7 ? 12'h249 :
              (idx == 3'd1 || idx == 3'd4 || idx == 3'd5) ? 12'h891 : 12'h889;
        rsum      = {1'b0, key_l} + {1'b0, off};
        root      = rsum >= 5'd12 ? 4'(rsum - 5'd12) : rsum[3:0];
        sh        = {12'b0, pat} << root;
        tmpl      = sh[11:0] | sh[23:12];
        score     = 3'($countones(tmpl & mask));
        better    = score > best;
        fin_score = better ? score : best;
        fin_idx   = better ? idx : best_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            bad       <= 1'b0;
            key_l     <= '0;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
            chord_out <= '0;
            note_mask <= '0;
            bad_note  <= 1'b0;
        end else begin
            if (accept) begin
                mask <= mask | (12'd1 << note_in);
                bad  <= bad | (note_in >= 4'd12);
            end
            if (fire) begin
                key_l    <= key;
                idx      <= 3'd1;
                best     <= '0;
                best_idx <= '0;
            end
            if (state == MATCH) begin
                idx <= idx + 3'd1;
                if (better) begin
                    best     <= score;
                    best_idx <= idx;
                end
                if (idx == 3'd7) begin
                    chord_out <= (key_l < 4'd12 && fin_score >= 3'd3) ? {1'b0, fin_idx} : 4'd0;
                    note_mask <= mask;
                    bad_note  <= bad;
                end
            end
            if (state == OUT && chord_ready) begin
                mask <= '0;
                bad  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_notes_to_chord.sv
// tb_notes_to_chord: directed frames with hand-computed chords, masks and latency.
module tb_notes_to_chord;
    logic        clk = 0, rst_n = 1;
    logic [3:0]  key = 0, note_in = 0;
    logic        note_valid = 0, frame_end = 0, chord_ready = 0;
    logic        note_ready, chord_valid, bad_note;
    logic [3:0]  chord_out;
    logic [11:0] note_mask;
    int          checks = 0, errors = 0;

    notes_to_chord dut (
        .clk(clk), .rst_n(rst_n), .key(key), .note_in(note_in),
        .note_valid(note_valid), .frame_end(frame_end), .note_ready(note_ready),
        .chord_out(chord_out), .chord_valid(chord_valid), .chord_ready(chord_ready),
        .note_mask(note_mask), .bad_note(bad_note)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Notes packed as nibbles, first note in the low nibble; returns one negedge after acceptance.
    task automatic send(input logic [3:0] k, input logic [31:0] nts, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            note_valid = 1;
            note_in    = nts[4*i +: 4];
        end
        @(negedge clk);
        note_valid = 0;
        frame_end  = 1;
        key        = k;
        @(negedge clk);
        frame_end = 0;
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!chord_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 7);
    endtask

    task automatic release_out(input string tag);
        chord_ready = 1;
        @(negedge clk);
        chord_ready = 0;
        chk({tag, "_valid_drop"}, chord_valid, 0);
        chk({tag, "_ready_back"}, note_ready, 1);
    endtask

    task automatic frame(input string tag, input logic [3:0] k, input logic [31:0] nts, input int n,
                         input logic [3:0] ec, input logic [11:0] em, input logic eb);
        send(k, nts, n);
        wait_valid(tag);
        chk({tag, "_chord"}, chord_out, ec);
        chk({tag, "_mask"}, note_mask, em);
        chk({tag, "_bad"}, bad_note, eb);
        release_out(tag);
    endtask

    initial begin
        logic seen;
        #3 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", chord_valid, 0);
        chk("rst_chord", chord_out, 0);
        chk("rst_mask", note_mask, 0);
        chk("rst_bad", bad_note, 0);
        chk("rst_ready", note_ready, 1);
        rst_n = 1;

        frame("maj7",     4'd0,  32'hB740,  4, 4'd1, 12'h891, 0);
        frame("key2",     4'd2,  32'h62B7,  4, 4'd5, 12'h8C4, 0);
        frame("dim7",     4'd0,  32'h3096,  4, 4'd7, 12'h249, 0);
        frame("triad",    4'd0,  32'h740,   3, 4'd1, 12'h091, 0);
        frame("below",    4'd0,  32'h96,    2, 4'd0, 12'h240, 0);
        frame("badnote",  4'd0,  32'hB740D, 5, 4'd1, 12'h891, 1);
        frame("empty",    4'd0,  32'h0,     0, 4'd0, 12'h000, 0);
        frame("badkey",   4'd12, 32'hB740,  4, 4'd0, 12'h891, 0);
        frame("extra",    4'd0,  32'h1B740, 5, 4'd1, 12'h893, 0);

        // Backpressure with a key change after acceptance and an ignored note in OUT.
        send(4'd0, 32'hB740, 4);
        key = 4'd5;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_chord", chord_out, 1);
            chk("bp_valid", chord_valid, 1);
            chk("bp_ready", note_ready, 0);
            chk("bp_mask", note_mask, 12'h891);
            note_valid = (i == 2);
            note_in    = 4'd2;
        end
        note_valid = 0;
        release_out("bp");
        frame("bp_next", 4'd0, 32'h96, 2, 4'd0, 12'h240, 0);

        // Reset in the third MATCH cycle abandons the frame.
        send(4'd0, 32'hB740, 4);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mrst_valid", chord_valid, 0);
        chk("mrst_chord", chord_out, 0);
        chk("mrst_mask", note_mask, 0);
        chk("mrst_bad", bad_note, 0);
        chk("mrst_ready", note_ready, 1);
        @(negedge clk);
        rst_n = 1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            seen |= chord_valid;
        end
        chk("mrst_no_result", seen, 0);
        frame("recover", 4'd2, 32'h62B7, 4, 4'd5, 12'h8C4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
